// File: rtl/efuse_access_arb_if.sv
// Bundle of every signal between efuse_access_arb, its requesters and the
// shared efuse read/write engine.
//   slave  : the arbiter's view (requests and engine status in; grants,
//            responses and engine commands out)
//   master : the surroundings' view (requesters plus engine)
// Requester vectors are packed with requester i at [i*W +: W].
interface efuse_access_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int NR      = 64,
  parameter int NW      = 64,
  parameter int SEL_W   = 2
);
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ-1:0]       req_wr;
  logic [NUM_REQ*SEL_W-1:0] req_sel;
  logic [NUM_REQ*NW-1:0]    req_wdata;
  logic [NUM_REQ-1:0]       req_gnt;
  logic [NUM_REQ-1:0]       rsp_done;
  logic                     rsp_err;
  logic [NR-1:0]            rsp_rdata;
  logic                     read_start;
  logic                     write_start;
  logic [SEL_W-1:0]         efuse_read_sel;
  logic [SEL_W-1:0]         efuse_write_sel;
  logic [NW-1:0]            write_data;
  logic                     read_done;
  logic [NR-1:0]            read_data;
  logic                     write_done;
  logic                     efuse_busy_read;
  logic                     efuse_busy_write;
  logic                     arb_busy;

  modport slave (
    input  req_vld, req_wr, req_sel, req_wdata,
    input  read_done, read_data, write_done, efuse_busy_read, efuse_busy_write,
    output req_gnt, rsp_done, rsp_err, rsp_rdata,
    output read_start, write_start, efuse_read_sel, efuse_write_sel, write_data,
    output arb_busy
  );

  modport master (
    output req_vld, req_wr, req_sel, req_wdata,
    output read_done, read_data, write_done, efuse_busy_read, efuse_busy_write,
    input  req_gnt, rsp_done, rsp_err, rsp_rdata,
    input  read_start, write_start, efuse_read_sel, efuse_write_sel, write_data,
    input  arb_busy
  );
endinterface

// File: rtl/efuse_access_arb.sv
// Shares one efuse read/write engine between NUM_REQ requesters. Requester 0
// (PMU autoload) has fixed top priority; the others are served round robin.
// The winner's command is latched at grant, a single start pulse is sent to
// the engine, and the op ends on the rising edge of the matching done or on
// a TIMEOUT_CYC timeout. Read data and a done/error pulse go back to the owner.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - efuse_access_arb_if.slave: requester handshake (req_vld/req_wr/
//          req_sel/req_wdata in, req_gnt/rsp_done/rsp_err/rsp_rdata out),
//          engine command (read_start/write_start/efuse_*_sel/write_data out,
//          read_done/read_data/write_done/efuse_busy_* in), arb_busy out.
module efuse_access_arb #(
  parameter int NUM_REQ     = 3,
  parameter int NR          = 64,
  parameter int NW          = 64,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 4095
) (
  input logic                clk,
  input logic                rst,
  efuse_access_arb_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   win;
  logic               wr_l;
  logic [CNT_W-1:0]   cnt;
  logic               read_done_q;
  logic               write_done_q;
  logic               done_rise;
  logic               go;
  logic [NUM_REQ-1:0] vld_sh;
  int                 idx;

  // Winner: requester 0 if asking, else the first asking requester at or
  // after rr_ptr, cycling over 1..NUM_REQ-1. The loop runs from the farthest
  // candidate down so the nearest one is the last to overwrite win.
  always_comb begin
    win    = '0;
    idx    = 0;
    vld_sh = '0;
    if (!bus.req_vld[0]) begin
      for (int k = NUM_REQ - 2; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
        vld_sh = bus.req_vld >> idx;
        if (vld_sh[0]) win = PTR_W'(idx);
      end
    end
  end

  assign go = (|bus.req_vld) & ~bus.efuse_busy_read & ~bus.efuse_busy_write;

  // Only the done belonging to the latched direction counts; the other is ignored.
  assign done_rise = wr_l ? (bus.write_done & ~write_done_q)
                          : (bus.read_done & ~read_done_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      rr_ptr              <= PTR_W'(1);
      owner               <= '0;
      wr_l                <= 1'b0;
      cnt                 <= '0;
      read_done_q         <= 1'b0;
      write_done_q        <= 1'b0;
      bus.req_gnt         <= '0;
      bus.rsp_done        <= '0;
      bus.rsp_err         <= 1'b0;
      bus.rsp_rdata       <= '0;
      bus.read_start      <= 1'b0;
      bus.write_start     <= 1'b0;
      bus.efuse_read_sel  <= '0;
      bus.efuse_write_sel <= '0;
      bus.write_data      <= '0;
      bus.arb_busy        <= 1'b0;
    end else begin
      read_done_q     <= bus.read_done;
      write_done_q    <= bus.write_done;
      bus.read_start  <= 1'b0;
      bus.write_start <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            owner               <= win;
            wr_l                <= bus.req_wr[win];
            bus.efuse_read_sel  <= bus.req_sel[int'(win)*SEL_W +: SEL_W];
            bus.efuse_write_sel <= bus.req_sel[int'(win)*SEL_W +: SEL_W];
            bus.write_data      <= bus.req_wdata[int'(win)*NW +: NW];
            bus.req_gnt         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            bus.arb_busy        <= 1'b1;
            state               <= START;
          end
        end
        START: begin
          if (wr_l) bus.write_start <= 1'b1;
          else      bus.read_start  <= 1'b1;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            if (!wr_l) bus.rsp_rdata <= bus.read_data;
            bus.rsp_err  <= 1'b0;
            bus.rsp_done <= bus.req_gnt;
            state        <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
            bus.rsp_err  <= 1'b1;
            bus.rsp_done <= bus.req_gnt;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.rsp_done <= '0;
          bus.rsp_err  <= 1'b0;
          bus.req_gnt  <= '0;
          bus.arb_busy <= 1'b0;
          // Requester 0 sits outside the rotation, so its wins leave rr_ptr alone.
          if (owner != '0) begin
            rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? PTR_W'(1) : owner + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_access_arb.sv
module tb_efuse_access_arb;
  localparam int NUM_REQ = 3;
  localparam int NR      = 64;
  localparam int NW      = 64;
  localparam int SEL_W   = 2;
  localparam int TO      = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  efuse_access_arb_if #(.NUM_REQ(NUM_REQ), .NR(NR), .NW(NW), .SEL_W(SEL_W)) bus ();

  efuse_access_arb #(
    .NUM_REQ(NUM_REQ), .NR(NR), .NW(NW), .SEL_W(SEL_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    logic               err;
    logic [NR-1:0]      rdata;
  } exp_t;

  typedef struct {
    int                 r;
    logic               wr;
    logic [SEL_W-1:0]   sel;
    logic [NW-1:0]      wd;
    int                 dly;      // engine done delay after start, -1 = never
    logic [NR-1:0]      rd;       // data the engine returns
    logic               exp_err;
    int                 exp_lat;  // start-visible to rsp_done-visible, cycles
    logic [NR-1:0]      exp_rd;   // rsp_rdata expected at completion
  } vec_t;

  exp_t               sb[$];
  exp_t               mon_e;
  vec_t               vt[7];
  vec_t               v;
  int                 tests = 0;
  int                 fails = 0;
  int                 cyc = 0;
  int                 done_seen = 0;
  int                 done_cyc = 0;
  logic [NUM_REQ-1:0] last_done = '0;
  int                 rs_cnt = 0;
  int                 ws_cnt = 0;
  int                 eng_dly = -1;
  logic [NR-1:0]      eng_rd = '0;
  int                 eng_cnt = 0;
  logic               eng_armed = 1'b0;
  logic               eng_wr = 1'b0;

  localparam logic [NR-1:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: every completion pops the oldest expected result.
  always @(negedge clk) begin
    if (bus.read_start)  rs_cnt++;
    if (bus.write_start) ws_cnt++;
    if (bus.read_start || bus.write_start)
      check("start_exclusive", 64'(bus.read_start & bus.write_start), 64'd0);
    if (|bus.rsp_done) begin
      done_seen++;
      done_cyc  = cyc;
      last_done = bus.rsp_done;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: rsp_done=%b with no op expected", bus.rsp_done);
      end else begin
        mon_e = sb.pop_front();
        check("done_owner", 64'(bus.rsp_done), 64'(mon_e.mask));
        check("done_err", 64'(bus.rsp_err), 64'(mon_e.err));
        check("done_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
      end
    end
  end

  // Engine model: answers each start pulse after eng_dly cycles with a
  // one-cycle done pulse; read_data carries garbage except during read_done.
  initial begin
    bus.read_done  = 1'b0;
    bus.write_done = 1'b0;
    bus.read_data  = GARBAGE;
    forever begin
      @(negedge clk);
      bus.read_done  = 1'b0;
      bus.write_done = 1'b0;
      bus.read_data  = GARBAGE;
      if (rst) begin
        eng_armed = 1'b0;
      end else begin
        if ((bus.read_start || bus.write_start) && eng_dly >= 0) begin
          eng_armed = 1'b1;
          eng_cnt   = eng_dly;
          eng_wr    = bus.write_start;
        end
        if (eng_armed) begin
          if (eng_cnt == 0) begin
            if (eng_wr) bus.write_done = 1'b1;
            else begin
              bus.read_done = 1'b1;
              bus.read_data = eng_rd;
            end
            eng_armed = 1'b0;
          end else begin
            eng_cnt--;
          end
        end
      end
    end
  end

  task automatic run_txn(input vec_t t);
    exp_t               e;
    logic [NUM_REQ-1:0] m;
    int                 n0, rs0, ws0, t_start, k;
    m       = NUM_REQ'(1 << t.r);
    e.mask  = m;
    e.err   = t.exp_err;
    e.rdata = t.exp_rd;
    sb.push_back(e);
    eng_dly = t.dly;
    eng_rd  = t.rd;
    n0      = done_seen;
    rs0     = rs_cnt;
    ws0     = ws_cnt;
    bus.req_vld[t.r]                  = 1'b1;
    bus.req_wr[t.r]                   = t.wr;
    bus.req_sel[t.r*SEL_W +: SEL_W]   = t.sel;
    bus.req_wdata[t.r*NW +: NW]       = t.wd;
    tick();
    check("grant_latency", 64'(bus.req_gnt), 64'(m));
    tick();
    t_start = cyc;
    check("read_start_latency", 64'(bus.read_start), 64'(!t.wr));
    check("write_start_latency", 64'(bus.write_start), 64'(t.wr));
    if (t.wr) begin
      check("write_sel", 64'(bus.efuse_write_sel), 64'(t.sel));
      check("write_data", 64'(bus.write_data), 64'(t.wd));
    end else begin
      check("read_sel", 64'(bus.efuse_read_sel), 64'(t.sel));
    end
    k = 0;
    while (done_seen == n0 && k < TO + 40) begin
      tick();
      k++;
    end
    if (done_seen == n0) begin
      tests++;
      fails++;
      $display("FAIL done_wait: no rsp_done within %0d cycles, required one", k);
    end else begin
      check("done_latency", 64'(done_cyc - t_start), 64'(t.exp_lat));
      check("gnt_at_done", 64'(bus.req_gnt), 64'(m));
      check("read_starts", 64'(rs_cnt - rs0), 64'(!t.wr));
      check("write_starts", 64'(ws_cnt - ws0), 64'(t.wr));
      if (t.wr) begin
        check("write_sel_held", 64'(bus.efuse_write_sel), 64'(t.sel));
        check("write_data_held", 64'(bus.write_data), 64'(t.wd));
      end else begin
        check("read_sel_held", 64'(bus.efuse_read_sel), 64'(t.sel));
      end
    end
    bus.req_vld[t.r] = 1'b0;
    tick();
    check("idle_after_txn", 64'(bus.arb_busy), 64'd0);
    check("gnt_cleared", 64'(bus.req_gnt), 64'd0);
  endtask

  // Waits for n completions; requesters in drop release req_vld on their done.
  task automatic wait_dones(input int n, input logic [NUM_REQ-1:0] drop);
    int n0, seen, k;
    n0   = done_seen;
    seen = done_seen;
    k    = 0;
    while (done_seen < n0 + n && k < 400) begin
      tick();
      k++;
      if (done_seen != seen) begin
        seen = done_seen;
        bus.req_vld = bus.req_vld & ~(last_done & drop);
      end
    end
    if (done_seen < n0 + n) begin
      tests++;
      fails++;
      $display("FAIL dones_wait: got %0d completions, required %0d", done_seen - n0, n);
    end
    bus.req_vld = '0;
    tick();
    tick();
    check("idle_after_seq", 64'(bus.arb_busy), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic push_exp(input logic [NUM_REQ-1:0] m, input logic [NR-1:0] rd);
    exp_t e;
    e.mask  = m;
    e.err   = 1'b0;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs0, ws0;
    // {r, wr, sel, wdata, dly, engine rdata, exp_err, exp_lat, exp_rdata}
    vt[0] = '{1, 1'b0, 2'd2, 64'd0,                   5,  64'hDEAD_BEEF_0123_4567, 1'b0, 6,      64'hDEAD_BEEF_0123_4567};
    vt[1] = '{0, 1'b0, 2'd1, 64'd0,                   1,  64'h1111_2222_3333_4444, 1'b0, 2,      64'h1111_2222_3333_4444};
    vt[2] = '{1, 1'b0, 2'd0, 64'd0,                   -1, 64'h0,                   1'b1, TO + 1, 64'h1111_2222_3333_4444};
    vt[3] = '{0, 1'b1, 2'd0, 64'hFFFF_0000_FFFF_0000, 0,  64'h0,                   1'b0, 1,      64'h1111_2222_3333_4444};
    vt[4] = '{1, 1'b0, 2'd3, 64'd0,                   8,  64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 9,      64'hA5A5_5A5A_0F0F_F0F0};
    vt[5] = '{2, 1'b1, 2'd1, 64'h1234,                -1, 64'h0,                   1'b1, TO + 1, 64'hA5A5_5A5A_0F0F_F0F0};
    vt[6] = '{2, 1'b1, 2'd3, 64'h55AA,                3,  64'h0,                   1'b0, 4,      64'hA5A5_5A5A_0F0F_F0F0};

    rst                  = 1'b1;
    bus.req_vld          = '0;
    bus.req_wr           = '0;
    bus.req_sel          = '0;
    bus.req_wdata        = '0;
    bus.efuse_busy_read  = 1'b0;
    bus.efuse_busy_write = 1'b0;
    tick();
    tick();
    check("rst_gnt", 64'(bus.req_gnt), 64'd0);
    check("rst_done", 64'(bus.rsp_done), 64'd0);
    check("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_starts", 64'({bus.read_start, bus.write_start}), 64'd0);
    check("rst_busy", 64'(bus.arb_busy), 64'd0);
    rst = 1'b0;
    tick();

    // Single transactions: reads, writes, timeouts.
    for (int i = 0; i < 7; i++) run_txn(vt[i]);

    // Priority and round robin: 0 first, then 1, 2 alternate while held.
    eng_dly = 2;
    eng_rd  = 64'h00C0_FFEE;
    push_exp(3'b001, 64'h00C0_FFEE);
    push_exp(3'b010, 64'h00C0_FFEE);
    push_exp(3'b100, 64'h00C0_FFEE);
    push_exp(3'b010, 64'h00C0_FFEE);
    push_exp(3'b100, 64'h00C0_FFEE);
    push_exp(3'b010, 64'h00C0_FFEE);
    push_exp(3'b100, 64'h00C0_FFEE);
    bus.req_wr  = '0;
    bus.req_vld = 3'b111;
    wait_dones(7, 3'b001);

    // Engine busy blocks grants; a withdrawn request never starts.
    rs0 = rs_cnt;
    ws0 = ws_cnt;
    bus.efuse_busy_write = 1'b1;
    bus.req_vld[1]       = 1'b1;
    repeat (4) begin
      tick();
      check("busy_no_grant", 64'(bus.req_gnt), 64'd0);
    end
    bus.req_vld[1] = 1'b0;
    tick();
    bus.efuse_busy_write = 1'b0;
    repeat (4) tick();
    check("withdraw_no_grant", 64'(bus.req_gnt), 64'd0);
    check("withdraw_no_start", 64'((rs_cnt - rs0) + (ws_cnt - ws0)), 64'd0);
    check("withdraw_idle", 64'(bus.arb_busy), 64'd0);

    // Busy read blocks until it falls, then the held request proceeds.
    eng_dly = 1;
    eng_rd  = 64'h77;
    push_exp(3'b100, 64'h77);
    bus.efuse_busy_read = 1'b1;
    bus.req_vld[2]      = 1'b1;
    repeat (3) begin
      tick();
      check("busy_read_no_grant", 64'(bus.req_gnt), 64'd0);
    end
    bus.efuse_busy_read = 1'b0;
    wait_dones(1, 3'b100);

    // Reset mid-WAIT: move rr_ptr to 2, hang an op from 2, reset, then 1 must win.
    v = '{1, 1'b0, 2'd1, 64'd0, 1, 64'h99, 1'b0, 2, 64'h99};
    run_txn(v);
    eng_dly                        = -1;
    bus.req_wr[2]                  = 1'b1;
    bus.req_sel[2*SEL_W +: SEL_W]  = 2'd2;
    bus.req_wdata[2*NW +: NW]      = 64'hABCD;
    bus.req_vld[2]                 = 1'b1;
    repeat (4) tick();
    check("pre_rst_busy", 64'(bus.arb_busy), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_gnt", 64'(bus.req_gnt), 64'd0);
    check("arst_done_err", 64'({bus.rsp_done, bus.rsp_err}), 64'd0);
    check("arst_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("arst_sels", 64'({bus.efuse_read_sel, bus.efuse_write_sel}), 64'd0);
    check("arst_wdata", 64'(bus.write_data), 64'd0);
    check("arst_busy", 64'(bus.arb_busy), 64'd0);
    bus.req_vld = '0;
    tick();
    rst = 1'b0;
    tick();
    eng_dly    = 2;
    eng_rd     = 64'h5151;
    push_exp(3'b010, 64'h5151);
    push_exp(3'b100, 64'h5151);
    bus.req_wr  = '0;
    bus.req_vld = 3'b110;
    tick();
    check("rr_after_reset", 64'(bus.req_gnt), 64'(3'b010));
    wait_dones(2, 3'b110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
